// File: rtl/cpu64_l2_pkg.sv
// Shared defaults, width helpers and byte-mask expansion for the L2 array bank.
package cpu64_l2_pkg;

    localparam int unsigned L2_WAYS           = 16;
    localparam int unsigned L2_SETS           = 256;
    localparam int unsigned L2_WORDS_PER_LINE = 8;
    localparam int unsigned L2_DATA_W         = 64;
    localparam int unsigned L2_TAG_W          = 50;

    // Byte-mask helper works on the widest supported word; callers truncate.
    localparam int unsigned MAX_DATA_W = 512;
    localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } bank_state_e;

    function automatic int unsigned width_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_DATA_W-1:0] be_to_mask(input logic [MAX_BE_W-1:0] be);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_BE_W; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/cpu64_l2_way_ram.sv
// One L2 way: byte-enabled data RAM plus tag RAM, read-first with registered outputs.
module cpu64_l2_way_ram
    import cpu64_l2_pkg::*;
#(
    parameter int unsigned SETS           = L2_SETS,
    parameter int unsigned WORDS_PER_LINE = L2_WORDS_PER_LINE,
    parameter int unsigned DATA_W         = L2_DATA_W,
    parameter int unsigned TAG_W          = L2_TAG_W,
    localparam int unsigned IDX_W         = $clog2(SETS),
    localparam int unsigned WSEL_W        = $clog2(WORDS_PER_LINE),
    localparam int unsigned BE_W          = DATA_W / 8,
    localparam int unsigned DEPTH         = SETS * WORDS_PER_LINE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  index,
    input  logic [WSEL_W-1:0] word,
    input  logic              data_we,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    input  logic              tag_we,
    input  logic [IDX_W-1:0]  tag_index,
    input  logic [TAG_W-1:0]  tag_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [TAG_W-1:0]  rtag
);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [DATA_W-1:0] bit_mask;
    logic [IDX_W+WSEL_W-1:0] addr;

    assign addr     = {index, word};
    assign bit_mask = DATA_W'(be_to_mask(MAX_BE_W'(be)));

    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_mem[addr] <= (data_mem[addr] & ~bit_mask) | (wdata & bit_mask);
        end
        if (tag_we) begin
            tag_mem[tag_index] <= tag_wdata;
        end
    end

    // Output registers sample the pre-write contents on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata <= '0;
            rtag  <= '0;
        end else if (rd_en) begin
            rdata <= data_mem[addr];
            rtag  <= tag_mem[index];
        end
    end

endmodule

// File: rtl/cpu64_l2_array_bank.sv
// L2 data/tag bank: WAYS way RAMs, tag-clear walk after reset, valid/ready request and held response.
module cpu64_l2_array_bank
    import cpu64_l2_pkg::*;
#(
    parameter int unsigned WAYS           = L2_WAYS,
    parameter int unsigned SETS           = L2_SETS,
    parameter int unsigned WORDS_PER_LINE = L2_WORDS_PER_LINE,
    parameter int unsigned DATA_W         = L2_DATA_W,
    parameter int unsigned TAG_W          = L2_TAG_W,
    localparam int unsigned IDX_W         = $clog2(SETS),
    localparam int unsigned WSEL_W        = $clog2(WORDS_PER_LINE),
    localparam int unsigned WAY_W         = width_min1(WAYS),
    localparam int unsigned BE_W          = DATA_W / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [IDX_W-1:0]       req_index_i,
    input  logic [WSEL_W-1:0]      req_word_i,
    input  logic [WAY_W-1:0]       req_way_i,
    input  logic                   req_data_we_i,
    input  logic                   req_tag_we_i,
    input  logic [BE_W-1:0]        req_be_i,
    input  logic [TAG_W-1:0]       req_tag_i,
    input  logic [DATA_W-1:0]      req_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DATA_W-1:0]      rsp_rdata_sel_o,
    output logic [TAG_W-1:0]       rsp_tag_sel_o,
    output logic [WAYS*DATA_W-1:0] rsp_rdata_flat_o,
    output logic [WAYS*TAG_W-1:0]  rsp_tag_flat_o,
    output logic                   init_done_o
);

    bank_state_e       state_q, state_d;
    logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
    logic              rsp_valid_q;
    logic [WAY_W-1:0]  sel_way_q;
    logic              in_init;
    logic              accept;
    logic [DATA_W-1:0] way_rdata [WAYS];
    logic [TAG_W-1:0]  way_tag   [WAYS];

    // Handshake: a request transfers on an edge where req_valid_i & req_ready_o; a
    // response transfers on an edge where rsp_valid_o & rsp_ready_i. The bank is ready
    // once the walk is done, outside reset, and when the response slot is empty or draining.
    assign in_init     = (state_q == ST_INIT);
    assign req_ready_o = (state_q == ST_READY) && !rst_i && (!rsp_valid_q || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = rsp_valid_q;
    assign init_done_o = (state_q == ST_READY);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            sel_way_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            if (accept) begin
                rsp_valid_q <= 1'b1;
                sel_way_q   <= req_way_i;
            end else if (rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: ;
            default: state_d = ST_INIT;
        endcase
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic way_hit;
        assign way_hit = (req_way_i == WAY_W'(w));

        // The walk owns the tag write port; requests cannot be accepted until it ends.
        cpu64_l2_way_ram #(
            .SETS           (SETS),
            .WORDS_PER_LINE (WORDS_PER_LINE),
            .DATA_W         (DATA_W),
            .TAG_W          (TAG_W)
        ) u_way_ram (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .rd_en     (accept),
            .index     (req_index_i),
            .word      (req_word_i),
            .data_we   (accept && req_data_we_i && way_hit),
            .be        (req_be_i),
            .wdata     (req_wdata_i),
            .tag_we    (in_init || (accept && req_tag_we_i && way_hit)),
            .tag_index (in_init ? init_cnt_q : req_index_i),
            .tag_wdata (in_init ? '0 : req_tag_i),
            .rdata     (way_rdata[w]),
            .rtag      (way_tag[w])
        );

        assign rsp_rdata_flat_o[w*DATA_W +: DATA_W] = way_rdata[w];
        assign rsp_tag_flat_o[w*TAG_W +: TAG_W]     = way_tag[w];
    end

    // A way number past WAYS never matches, leaving the selected outputs at zero.
    always_comb begin
        rsp_rdata_sel_o = '0;
        rsp_tag_sel_o   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (sel_way_q == WAY_W'(w)) begin
                rsp_rdata_sel_o = way_rdata[w];
                rsp_tag_sel_o   = way_tag[w];
            end
        end
    end

endmodule

// File: tb/tb_cpu64_l2_array_bank.sv
// Bench for cpu64_l2_array_bank: directed scenarios plus random traffic against an array model.
module tb_cpu64_l2_array_bank;

    localparam int WAYS   = 16;
    localparam int SETS   = 256;
    localparam int WPL    = 8;
    localparam int DW     = 64;
    localparam int TW     = 50;
    localparam int IDX_W  = 8;
    localparam int WSEL_W = 3;
    localparam int WAY_W  = 4;
    localparam int BE_W   = 8;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_i = 1'b0;
    logic                 req_valid_i = 1'b0;
    logic                 req_ready_o;
    logic [IDX_W-1:0]     req_index_i = '0;
    logic [WSEL_W-1:0]    req_word_i = '0;
    logic [WAY_W-1:0]     req_way_i = '0;
    logic                 req_data_we_i = 1'b0;
    logic                 req_tag_we_i = 1'b0;
    logic [BE_W-1:0]      req_be_i = '0;
    logic [TW-1:0]        req_tag_i = '0;
    logic [DW-1:0]        req_wdata_i = '0;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i = 1'b1;
    logic [DW-1:0]        rsp_rdata_sel_o;
    logic [TW-1:0]        rsp_tag_sel_o;
    logic [WAYS*DW-1:0]   rsp_rdata_flat_o;
    logic [WAYS*TW-1:0]   rsp_tag_flat_o;
    logic                 init_done_o;

    cpu64_l2_array_bank #(
        .WAYS(WAYS), .SETS(SETS), .WORDS_PER_LINE(WPL), .DATA_W(DW), .TAG_W(TW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_index_i      (req_index_i),
        .req_word_i       (req_word_i),
        .req_way_i        (req_way_i),
        .req_data_we_i    (req_data_we_i),
        .req_tag_we_i     (req_tag_we_i),
        .req_be_i         (req_be_i),
        .req_tag_i        (req_tag_i),
        .req_wdata_i      (req_wdata_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_rdata_sel_o  (rsp_rdata_sel_o),
        .rsp_tag_sel_o    (rsp_tag_sel_o),
        .rsp_rdata_flat_o (rsp_rdata_flat_o),
        .rsp_tag_flat_o   (rsp_tag_flat_o),
        .init_done_o      (init_done_o)
    );

    // scoreboard: expected responses and the array model
    typedef struct packed {
        logic [WAYS*DW-1:0] dflat;
        logic [WAYS*DW-1:0] dmask;
        logic [WAYS*TW-1:0] tflat;
        logic [DW-1:0]      dsel;
        logic [DW-1:0]      smask;
        logic [TW-1:0]      tsel;
    } exp_t;

    exp_t        exp_q[$];
    logic [DW-1:0] m_data  [WAYS][SETS*WPL];
    logic [DW-1:0] m_known [WAYS][SETS*WPL];
    logic [TW-1:0] m_tag   [WAYS][SETS];
    int  m_k = 0;
    bit  m_pending = 1'b0;
    bit  m_state_known = 1'b0;
    bit  last_accept = 1'b0;
    int  n_total = 0;
    int  n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: compare outputs with the model at negedge, then advance the model.
    task automatic step();
        logic exp_ready;
        exp_t e;
        int   a;
        int   idx;
        int   way;
        @(negedge clk);
        last_accept = 1'b0;
        if (m_state_known) begin
            exp_ready = (m_k >= SETS) && !rst_i && (!m_pending || rsp_ready_i);
            check("init_done", 64'(init_done_o), 64'(m_k >= SETS));
            check("req_ready", 64'(req_ready_o), 64'(exp_ready));
            check("rsp_valid", 64'(rsp_valid_o), 64'(m_pending));
            if (m_pending) begin
                e = exp_q[0];
                for (int w = 0; w < WAYS; w++) begin
                    check($sformatf("rdata_flat[%0d]", w),
                          rsp_rdata_flat_o[w*DW +: DW] & e.dmask[w*DW +: DW], e.dflat[w*DW +: DW]);
                    check($sformatf("tag_flat[%0d]", w),
                          64'(rsp_tag_flat_o[w*TW +: TW]), 64'(e.tflat[w*TW +: TW]));
                end
                check("rdata_sel", rsp_rdata_sel_o & e.smask, e.dsel);
                check("tag_sel", 64'(rsp_tag_sel_o), 64'(e.tsel));
                if (rsp_ready_i) begin
                    void'(exp_q.pop_front());
                    m_pending = 1'b0;
                end
            end
            if (exp_ready && req_valid_i) begin
                idx = int'(req_index_i);
                way = int'(req_way_i);
                a   = idx * WPL + int'(req_word_i);
                for (int w = 0; w < WAYS; w++) begin
                    e.dflat[w*DW +: DW] = m_data[w][a] & m_known[w][a];
                    e.dmask[w*DW +: DW] = m_known[w][a];
                    e.tflat[w*TW +: TW] = m_tag[w][idx];
                end
                if (way < WAYS) begin
                    e.dsel  = m_data[way][a] & m_known[way][a];
                    e.smask = m_known[way][a];
                    e.tsel  = m_tag[way][idx];
                    for (int b = 0; b < BE_W; b++) begin
                        if (req_data_we_i && req_be_i[b]) begin
                            m_data[way][a][8*b +: 8]  = req_wdata_i[8*b +: 8];
                            m_known[way][a][8*b +: 8] = 8'hFF;
                        end
                    end
                    if (req_tag_we_i) m_tag[way][idx] = req_tag_i;
                end else begin
                    e.dsel  = '0;
                    e.smask = '1;
                    e.tsel  = '0;
                end
                exp_q.push_back(e);
                m_pending   = 1'b1;
                last_accept = 1'b1;
            end
        end
        @(posedge clk);
        if (rst_i) begin
            m_state_known = 1'b1;
            m_k = 0;
            m_pending = 1'b0;
            exp_q.delete();
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) m_tag[w][s] = '0;
        end else if (m_k < SETS) begin
            m_k++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        req_valid_i = 1'b0;
        repeat (n) step();
    endtask

    // driver: present one request and hold it until accepted (bounded)
    task automatic do_req(input int idx, input int word, input int way, input bit dwe, input bit twe,
                          input logic [BE_W-1:0] be, input logic [TW-1:0] tag, input logic [DW-1:0] wd,
                          output int cycles);
        req_index_i   = IDX_W'(idx);
        req_word_i    = WSEL_W'(word);
        req_way_i     = WAY_W'(way);
        req_data_we_i = dwe;
        req_tag_we_i  = twe;
        req_be_i      = be;
        req_tag_i     = tag;
        req_wdata_i   = wd;
        req_valid_i   = 1'b1;
        cycles = 0;
        do begin
            step();
            cycles++;
            if (cycles >= 4) rsp_ready_i = 1'b1;
        end while (!last_accept && cycles < 64);
        check("req_accept", 64'(last_accept), 64'(1));
        req_valid_i = 1'b0;
    endtask

    task automatic do_read(input int idx, input int word, input int way);
        int c;
        do_req(idx, word, way, 1'b0, 1'b0, '0, '0, '0, c);
    endtask

    task automatic do_write(input int idx, input int word, input int way,
                            input logic [BE_W-1:0] be, input logic [DW-1:0] wd);
        int c;
        do_req(idx, word, way, 1'b1, 1'b0, be, '0, wd, c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int rs;
        for (int w = 0; w < WAYS; w++) begin
            for (int a = 0; a < SETS*WPL; a++) begin
                m_data[w][a]  = '0;
                m_known[w][a] = '0;
            end
            for (int s = 0; s < SETS; s++) m_tag[w][s] = '0;
        end

        // reset and init walk timing
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("rst_rdata_sel", rsp_rdata_sel_o, 64'(0));
        idle(SETS - 1);
        check("init_done_early", 64'(init_done_o), 64'(0));
        idle(1);
        check("init_done_exact", 64'(init_done_o), 64'(1));
        check("ready_after_init", 64'(req_ready_o), 64'(1));

        // any set reads back cleared tags
        rs = $urandom_range(0, SETS - 1);
        do_read(rs, $urandom_range(0, WPL - 1), 0);
        check("tags_cleared", 64'(|rsp_tag_flat_o), 64'(0));

        // full write then byte-masked merge
        do_write(8'h12, 5, 3, 8'hFF, 64'h1122334455667788);
        do_read(8'h12, 5, 3);
        check("sel_full_write", rsp_rdata_sel_o, 64'h1122334455667788);
        check("flat3_full_write", rsp_rdata_flat_o[3*DW +: DW], 64'h1122334455667788);
        do_write(8'h12, 5, 3, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        do_read(8'h12, 5, 3);
        check("sel_merge", rsp_rdata_sel_o, 64'h11223344AAAAAAAA);

        // zero byte enables still respond and leave data alone
        do_write(8'h12, 5, 3, 8'h00, 64'h5555555555555555);
        do_read(8'h12, 5, 3);
        check("sel_be_zero", rsp_rdata_sel_o, 64'h11223344AAAAAAAA);

        // read-first, then the new value one cycle later
        do_write(8'h12, 5, 3, 8'hFF, 64'hCAFEF00DDEADBEEF);
        check("read_first_old", rsp_rdata_sel_o, 64'h11223344AAAAAAAA);
        do_read(8'h12, 5, 3);
        check("read_after_write", rsp_rdata_sel_o, 64'hCAFEF00DDEADBEEF);
        idle(1);

        // backpressure: response held, pending write stalled
        rsp_ready_i = 1'b0;
        do_read(8'h12, 5, 3);
        req_index_i = 8'h12; req_word_i = 3'd5; req_way_i = 4'd3;
        req_data_we_i = 1'b1; req_tag_we_i = 1'b0; req_be_i = 8'hFF;
        req_wdata_i = 64'h0F0F0F0F0F0F0F0F; req_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_no_accept", 64'(last_accept), 64'(0));
            check("bp_ready_low", 64'(req_ready_o), 64'(0));
            check("bp_sel_stable", rsp_rdata_sel_o, 64'hCAFEF00DDEADBEEF);
        end
        rsp_ready_i = 1'b1;
        do_req(8'h12, 5, 3, 1'b1, 1'b0, 8'hFF, '0, 64'h0F0F0F0F0F0F0F0F, c);
        check("bp_release_1cycle", 64'(c), 64'(1));
        for (int wd = 0; wd < WPL; wd++) begin
            do_req(8'h12, wd, 3, 1'b0, 1'b0, '0, '0, '0, c);
            check("back_to_back", 64'(c), 64'(1));
        end
        idle(1);

        // random traffic on a small window of sets
        for (int i = 0; i < 400; i++) begin
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
            do_req(8'h40 + $urandom_range(0, 3), $urandom_range(0, WPL - 1), $urandom_range(0, WAYS - 1),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                   {18'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)}, c);
        end
        rsp_ready_i = 1'b1;
        idle(2);

        // tag write on way 15, then reset while a response is pending
        do_req(8'h12, 5, 15, 1'b1, 1'b1, 8'hFF, 50'h3_FFFF_FFFF_FFFF, 64'h0123456789ABCDEF, c);
        do_read(8'h12, 5, 15);
        check("tag15_written", 64'(rsp_tag_sel_o), 64'(50'h3_FFFF_FFFF_FFFF));
        idle(1);
        rsp_ready_i = 1'b0;
        do_read(8'h12, 5, 15);
        idle(1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        check("mid_rst_init_done", 64'(init_done_o), 64'(0));
        rsp_ready_i = 1'b1;
        idle(SETS);
        check("reinit_done", 64'(init_done_o), 64'(1));
        do_read(8'h12, 5, 15);
        check("tag15_recleared", 64'(rsp_tag_sel_o), 64'(0));
        check("data15_retained", rsp_rdata_sel_o, 64'h0123456789ABCDEF);
        check("data3_retained", rsp_rdata_flat_o[3*DW +: DW], 64'h0F0F0F0F0F0F0F0F);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
